read_counter_sequencer: RTL and testbench

- Closed-loop sequencer for one CDU angle channel.
- Holds the WIDTH-bit read (angle) counter and steps it toward null using the error comparator outputs.
- Drives the active-low bit lines _D5.._D8 that feed the sine/cosine quadrant selector.
- Issues one-cycle count pulses toward the AGC interface, with a settle delay after every counter change so the ladder/selector outputs are stable before the next comparison.

---
 rtl/cdu_pkg.sv | 19 +
 rtl/read_counter_sequencer.sv | 141 ++++++++++++++
 tb/tb_read_counter_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdu_pkg.sv
// Shared CDU definitions: sequencer state encoding, default counter width and
// the count-to-bit-line mapping used by both this block and the quadrant selector.
package cdu_pkg;

  localparam int CDU_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    STEP   = 2'd3
  } cdu_state_e;

  // Top nibble of the read counter -> {_D5,_D6,_D7,_D8}, active-low.
  function automatic logic [3:0] cdu_qsel(input logic [3:0] msn);
    return ~msn;
  endfunction

endpackage

// File: rtl/read_counter_sequencer.sv
// Closed-loop read counter sequencer for one CDU angle channel: settles, samples
// the error comparators, steps the counter and pulses the AGC count lines.
// States: IDLE loop off | SETTLE wait for ladder | SAMPLE read comparators | STEP move counter
module read_counter_sequencer
  import cdu_pkg::*;
#(
  parameter int WIDTH         = CDU_WIDTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int FAST_SHIFT    = 4,
  parameter int LOCK_COUNT    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             zero,
  input  logic             err_pos,
  input  logic             err_neg,
  input  logic             err_fast,
  output logic [WIDTH-1:0] count,
  output logic             _D5,
  output logic             _D6,
  output logic             _D7,
  output logic             _D8,
  output logic             cnt_up,
  output logic             cnt_dn,
  output logic             cnt_fast,
  output logic             locked
);

  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  localparam int NW = $clog2(LOCK_COUNT + 1);
  localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES);
  localparam logic [NW-1:0]    LOCK_N      = NW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] FAST_STEP   = WIDTH'(2 ** FAST_SHIFT);

  cdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, step_size;
  logic [TW-1:0]    timer_q, timer_d;
  logic [NW-1:0]    null_q, null_d;
  logic             dir_up_q, dir_up_d;
  logic             fast_q, fast_d;
  logic             up_q, up_d, dn_q, dn_d, cfast_q, cfast_d;
  logic             locked_q, locked_d;
  logic [3:0]       qsel_q, qsel_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    null_d    = null_q;
    dir_up_d  = dir_up_q;
    fast_d    = fast_q;
    up_d      = 1'b0;
    dn_d      = 1'b0;
    cfast_d   = 1'b0;
    locked_d  = locked_q;
    step_size = fast_q ? FAST_STEP : WIDTH'(1);

    // Loop disable and zero both override whatever step the FSM had pending.
    if (!en) begin
      state_d  = IDLE;
      null_d   = '0;
      locked_d = 1'b0;
      if (zero) count_d = '0;
    end else if (zero) begin
      count_d  = '0;
      null_d   = '0;
      locked_d = 1'b0;
      state_d  = SETTLE;
      timer_d  = SETTLE_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          timer_d  = SETTLE_LOAD;
          locked_d = 1'b0;
        end
        SETTLE: begin
          timer_d = timer_q - TW'(1);
          if (timer_q == TW'(1)) state_d = SAMPLE;
        end
        SAMPLE: begin
          dir_up_d = err_pos;
          fast_d   = err_fast;
          if (null_q == LOCK_N) locked_d = 1'b1;
          if (err_pos ^ err_neg) state_d = STEP;
          else if (null_q != LOCK_N) null_d = null_q + NW'(1);
        end
        STEP: begin
          count_d  = dir_up_q ? count_q + step_size : count_q - step_size;
          up_d     = dir_up_q;
          dn_d     = ~dir_up_q;
          cfast_d  = fast_q;
          null_d   = '0;
          locked_d = 1'b0;
          state_d  = SETTLE;
          timer_d  = SETTLE_LOAD;
        end
        default: state_d = IDLE;
      endcase
    end

    qsel_d = cdu_qsel(count_d[WIDTH-1 -: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      count_q  <= '0;
      timer_q  <= SETTLE_LOAD;
      null_q   <= '0;
      dir_up_q <= 1'b0;
      fast_q   <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      cfast_q  <= 1'b0;
      locked_q <= 1'b0;
      qsel_q   <= 4'b1111;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      null_q   <= null_d;
      dir_up_q <= dir_up_d;
      fast_q   <= fast_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      cfast_q  <= cfast_d;
      locked_q <= locked_d;
      qsel_q   <= qsel_d;
    end
  end

  assign count                = count_q;
  assign {_D5, _D6, _D7, _D8} = qsel_q;
  assign cnt_up               = up_q;
  assign cnt_dn               = dn_q;
  assign cnt_fast             = cfast_q;
  assign locked               = locked_q;

endmodule

// File: tb/tb_read_counter_sequencer.sv
// Self-checking bench for read_counter_sequencer: directed scenarios plus a
// randomized step/null sequence checked against an arithmetic angle model.
module tb_read_counter_sequencer;

  localparam int SETTLE = 4;
  localparam int LOCKN  = 3;
  localparam int FSTEP  = 16;
  localparam int PERIOD = SETTLE + 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic        zero  = 1'b0;
  logic        err_pos = 1'b0, err_neg = 1'b0, err_fast = 1'b0;
  logic [15:0] count;
  logic        d5, d6, d7, d8;
  logic        cnt_up, cnt_dn, cnt_fast, locked;

  int tests = 0;
  int fails = 0;
  int model = 0;   // expected angle count, 0..65535

  always #5 clk = ~clk;

  read_counter_sequencer #(
    .WIDTH(16), .SETTLE_CYCLES(SETTLE), .FAST_SHIFT(4), .LOCK_COUNT(LOCKN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .zero(zero),
    .err_pos(err_pos), .err_neg(err_neg), .err_fast(err_fast),
    .count(count), ._D5(d5), ._D6(d6), ._D7(d7), ._D8(d8),
    .cnt_up(cnt_up), .cnt_dn(cnt_dn), .cnt_fast(cnt_fast), .locked(locked)
  );

  // Bit lines are the inverted top nibble of the angle.
  function automatic logic [3:0] exp_d(input int c);
    int nib;
    nib = (c / 4096) % 16;
    return 4'(15 - nib);
  endfunction

  // Present one error direction and wait for the resulting counter step.
  task automatic do_step(input bit up, input bit fast, input int exp_gap);
    int  gap;
    bit  seen;
    int  stepv;
    err_pos  = up;
    err_neg  = !up;
    err_fast = fast;
    stepv = fast ? FSTEP : 1;
    model = up ? (model + stepv) % 65536 : (model - stepv + 65536) % 65536;
    seen = 0;
    gap  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      gap = i;
      if (cnt_up || cnt_dn) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL step_timeout: no count pulse within %0d cycles, required one", gap);
    end else begin
      tests++;
      if (cnt_up !== up || cnt_dn !== !up) begin
        fails++;
        $display("FAIL step_dir: up/dn=%b%b, required %b%b", cnt_up, cnt_dn, up, !up);
      end
      tests++;
      if (cnt_fast !== fast) begin
        fails++;
        $display("FAIL step_fast: cnt_fast=%b, required %b", cnt_fast, fast);
      end
      tests++;
      if (count !== 16'(model)) begin
        fails++;
        $display("FAIL step_count: count=%h, required %h", count, 16'(model));
      end
      tests++;
      if ({d5, d6, d7, d8} !== exp_d(model)) begin
        fails++;
        $display("FAIL step_dbits: D5..D8=%b, required %b", {d5, d6, d7, d8}, exp_d(model));
      end
      tests++;
      if (locked !== 1'b0) begin
        fails++;
        $display("FAIL step_locked: locked=%b, required 0", locked);
      end
      if (exp_gap != 0) begin
        tests++;
        if (gap != exp_gap) begin
          fails++;
          $display("FAIL step_gap: pulse after %0d cycles, required %0d", gap, exp_gap);
        end
      end
    end
  endtask

  task automatic zero_pulse();
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    model = 0;
    tests++;
    if (count !== 16'h0000 || cnt_up || cnt_dn) begin
      fails++;
      $display("FAIL zero_pulse: count=%h up=%b dn=%b, required 0000 0 0", count, cnt_up, cnt_dn);
    end
  endtask

  task automatic goto_count(input int target);
    zero_pulse();
    repeat (target / FSTEP) do_step(1'b1, 1'b1, PERIOD);
    repeat (target % FSTEP) do_step(1'b1, 1'b0, PERIOD);
  endtask

  task automatic test_reset();
    en = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    tests++;
    if (count !== 16'h0000 || {d5, d6, d7, d8} !== 4'b1111) begin
      fails++;
      $display("FAIL reset_count: count=%h D=%b, required 0000 1111", count, {d5, d6, d7, d8});
    end
    tests++;
    if ({cnt_up, cnt_dn, cnt_fast, locked} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: up/dn/fast/locked=%b, required 0000", {cnt_up, cnt_dn, cnt_fast, locked});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    for (int i = 1; i <= 3; i++) begin
      do_step(1'b1, 1'b0, PERIOD);
      tests++;
      if (count !== 16'(i)) begin
        fails++;
        $display("FAIL count_up: count=%h, required %h", count, 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid_step();
    do_step(1'b1, 1'b0, PERIOD);
    repeat (PERIOD - 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (count !== 16'h0000 || {d5, d6, d7, d8} !== 4'b1111 || cnt_up || cnt_dn || locked) begin
      fails++;
      $display("FAIL reset_mid_step: count=%h D=%b up=%b dn=%b lk=%b, required 0000 1111 0 0 0",
               count, {d5, d6, d7, d8}, cnt_up, cnt_dn, locked);
    end
    @(negedge clk);
    tests++;
    if (count !== 16'h0000 || cnt_up || cnt_dn) begin
      fails++;
      $display("FAIL reset_hold: count=%h up=%b dn=%b, required 0000 0 0", count, cnt_up, cnt_dn);
    end
    rst_n = 1'b1;
    model = 0;
    do_step(1'b1, 1'b0, PERIOD);
  endtask

  task automatic test_fast_carry();
    goto_count(16'h0FFC);
    tests++;
    if (count !== 16'h0FFC || {d5, d6, d7, d8} !== 4'b1111) begin
      fails++;
      $display("FAIL carry_pre: count=%h D=%b, required 0ffc 1111", count, {d5, d6, d7, d8});
    end
    do_step(1'b1, 1'b1, PERIOD);
    tests++;
    if (count !== 16'h100C || {d5, d6, d7, d8} !== 4'b1110 || cnt_fast !== 1'b1) begin
      fails++;
      $display("FAIL carry_post: count=%h D=%b fast=%b, required 100c 1110 1", count, {d5, d6, d7, d8}, cnt_fast);
    end
  endtask

  task automatic test_wrap();
    zero_pulse();
    do_step(1'b0, 1'b0, PERIOD);
    tests++;
    if (count !== 16'hFFFF || {d5, d6, d7, d8} !== 4'b0000) begin
      fails++;
      $display("FAIL wrap_down: count=%h D=%b, required ffff 0000", count, {d5, d6, d7, d8});
    end
    do_step(1'b1, 1'b0, PERIOD);
    tests++;
    if (count !== 16'h0000 || {d5, d6, d7, d8} !== 4'b1111) begin
      fails++;
      $display("FAIL wrap_up: count=%h D=%b, required 0000 1111", count, {d5, d6, d7, d8});
    end
    do_step(1'b0, 1'b0, PERIOD);
  endtask

  task automatic test_lock();
    err_pos = 1'b0;
    err_neg = 1'b0;
    for (int k = 1; k <= SETTLE + LOCKN + 1; k++) begin
      @(negedge clk);
      if (k == SETTLE + LOCKN) begin
        tests++;
        if (locked !== 1'b0) begin
          fails++;
          $display("FAIL lock_early: locked=%b after %0d nulls, required 0", locked, LOCKN);
        end
      end
    end
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL lock_set: locked=%b, required 1", locked);
    end
    err_pos = 1'b1;
    err_neg = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (locked !== 1'b1 || cnt_up || cnt_dn || count !== 16'(model)) begin
        fails++;
        $display("FAIL lock_both: locked=%b up=%b dn=%b count=%h, required 1 0 0 %h",
                 locked, cnt_up, cnt_dn, count, 16'(model));
      end
    end
    do_step(1'b0, 1'b0, 2);
  endtask

  task automatic test_zero_settle();
    goto_count(16'h1234);
    err_pos = 1'b0;
    err_neg = 1'b0;
    @(negedge clk);
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    model = 0;
    tests++;
    if (count !== 16'h0000 || cnt_up || cnt_dn || {d5, d6, d7, d8} !== 4'b1111) begin
      fails++;
      $display("FAIL zero_settle: count=%h up=%b dn=%b D=%b, required 0000 0 0 1111",
               count, cnt_up, cnt_dn, {d5, d6, d7, d8});
    end
  endtask

  task automatic test_zero_step();
    do_step(1'b1, 1'b0, 0);
    repeat (PERIOD - 1) @(negedge clk);
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    model = 0;
    tests++;
    if (count !== 16'h0000 || cnt_up || cnt_dn) begin
      fails++;
      $display("FAIL zero_step: count=%h up=%b dn=%b, required 0000 0 0", count, cnt_up, cnt_dn);
    end
  endtask

  task automatic test_en_drop();
    bit pulsed;
    do_step(1'b1, 1'b0, PERIOD);
    repeat (PERIOD - 1) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    tests++;
    if (count !== 16'(model) || cnt_up || cnt_dn || locked) begin
      fails++;
      $display("FAIL en_drop: count=%h up=%b dn=%b lk=%b, required %h 0 0 0",
               count, cnt_up, cnt_dn, locked, 16'(model));
    end
    pulsed = 0;
    repeat (10) begin
      @(negedge clk);
      if (cnt_up || cnt_dn) pulsed = 1;
    end
    tests++;
    if (count !== 16'(model) || pulsed) begin
      fails++;
      $display("FAIL idle_hold: count=%h pulsed=%b, required %h 0", count, pulsed, 16'(model));
    end
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    model = 0;
    tests++;
    if (count !== 16'h0000) begin
      fails++;
      $display("FAIL idle_zero: count=%h, required 0000", count);
    end
    en = 1'b1;
    do_step(1'b1, 1'b0, PERIOD + 1);
  endtask

  task automatic test_random();
    int  k;
    bit  up, fast;
    for (int n = 0; n < 40; n++) begin
      k    = int'($urandom_range(0, 3));
      up   = 1'($urandom_range(0, 1));
      fast = 1'($urandom_range(0, 1));
      if (k == 0) begin
        do_step(up, fast, PERIOD);
      end else begin
        if ($urandom_range(0, 1) == 1) {err_pos, err_neg} = 2'b11;
        else {err_pos, err_neg} = 2'b00;
        err_fast = 1'($urandom_range(0, 1));
        repeat (SETTLE + k) @(negedge clk);
        tests++;
        if (count !== 16'(model) || cnt_up || cnt_dn) begin
          fails++;
          $display("FAIL rand_null: count=%h up=%b dn=%b, required %h 0 0", count, cnt_up, cnt_dn, 16'(model));
        end
        do_step(up, fast, 2);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_up();
    test_reset_mid_step();
    test_fast_carry();
    test_wrap();
    test_lock();
    test_zero_settle();
    test_zero_step();
    test_en_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
